// File: rtl/dlx_operand_if.sv
// dlx_operand_if: instruction handshake, ALU command and writeback bundle
// for the DLX operand-fetch stage. "master" is the surrounding pipeline,
// "slave" is the operand stage itself.
interface dlx_operand_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        I;
  logic              EX;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [REG_AW-1:0] dst_rd;
  logic              illegal;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output instr, instr_valid, wb_we, wb_rd, wb_data,
    input  instr_ready, I, EX, op1, op2, dst_rd, illegal
  );

  modport slave (
    input  instr, instr_valid, wb_we, wb_rd, wb_data,
    output instr_ready, I, EX, op1, op2, dst_rd, illegal
  );
endinterface

// File: rtl/dlx_operand_stage.sv
// dlx_operand_stage: DLX decode / operand fetch in front of the ALU.
// Holds the register file and a per-register busy scoreboard, stalls on
// RAW/WAW hazards and issues a registered ALU command one cycle after
// acceptance. Optional feature macro: DLX_WB_BYPASS_EN -- when defined, a
// writeback in the same cycle resolves a hazard and forwards wb_data into
// the operand read (zero-bubble dependency resolution).
module dlx_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  dlx_operand_if.slave bus
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SEQ = 4'd10;
  localparam logic [3:0] OP_SLE = 4'd11;
  localparam logic [3:0] OP_SLT = 4'd12;
  localparam logic [3:0] OP_SNE = 4'd13;
  localparam logic [3:0] OP_SRA = 4'd14;

  // R-type function field to ALU op; 0 means unsupported
  function automatic logic [3:0] decode_r(input logic [5:0] func);
    logic [3:0] op;
    op = 4'd0;
    case (func)
      6'h20:   op = OP_ADD;
      6'h22:   op = OP_SUB;
      6'h24:   op = OP_AND;
      6'h25:   op = OP_OR;
      6'h26:   op = OP_XOR;
      6'h04:   op = OP_SLL;
      6'h06:   op = OP_SRL;
      6'h07:   op = OP_SRA;
      6'h28:   op = OP_SEQ;
      6'h29:   op = OP_SNE;
      6'h2A:   op = OP_SLT;
      6'h2C:   op = OP_SLE;
      default: op = 4'd0;
    endcase
    return op;
  endfunction

  // I-type opcode to ALU op; 0 means unsupported
  function automatic logic [3:0] decode_i(input logic [5:0] opc);
    logic [3:0] op;
    op = 4'd0;
    case (opc)
      6'h08:   op = OP_ADD;
      6'h0A:   op = OP_SUB;
      6'h0C:   op = OP_AND;
      6'h0D:   op = OP_OR;
      6'h0E:   op = OP_XOR;
      6'h14:   op = OP_SLL;
      6'h16:   op = OP_SRL;
      6'h17:   op = OP_SRA;
      6'h18:   op = OP_SEQ;
      6'h19:   op = OP_SNE;
      6'h1A:   op = OP_SLT;
      6'h1C:   op = OP_SLE;
      default: op = 4'd0;
    endcase
    return op;
  endfunction

  // Signed 16-bit immediate widened to the datapath width
  function automatic logic signed [DATA_W-1:0] sign_ext(input logic signed [15:0] v);
    logic signed [DATA_W-1:0] r;
    r = v;
    return r;
  endfunction

  // Logical immediates (ANDI/ORI/XORI) are widened without sign
  function automatic logic [DATA_W-1:0] zero_ext(input logic [15:0] v);
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [NREG-1:0]   busy_eff;
  logic [NREG-1:0]   wb_vec;

  logic [5:0]        opcode;
  logic [5:0]        func;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [15:0]       imm;
  logic              is_r;
  logic [3:0]        dec_op;
  logic              legal;
  logic              zext;
  logic              hazard;
  logic              xfer;
  logic              issue;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] op2_sel;

  logic              vld_p1;
  logic              illegal_p1;
  logic [3:0]        i_p1;
  logic [DATA_W-1:0] op1_p1;
  logic [DATA_W-1:0] op2_p1;
  logic [REG_AW-1:0] dst_p1;

  logic unused_shamt;
  assign unused_shamt = ^bus.instr[10:6];

  assign opcode = bus.instr[31:26];
  assign func   = bus.instr[5:0];
  assign rs1    = bus.instr[25:21];
  assign rs2    = bus.instr[20:16];
  assign imm    = bus.instr[15:0];
  assign is_r   = (opcode == 6'h00);
  assign rd     = is_r ? bus.instr[15:11] : bus.instr[20:16];

  // Decode the op code and immediate extension mode
  always_comb begin
    dec_op = is_r ? decode_r(func) : decode_i(opcode);
    legal  = (dec_op != 4'd0);
    zext   = !is_r && (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E);
  end

  // One-hot of the register being written back this cycle (never r0)
  always_comb begin
    wb_vec = '0;
    if (bus.wb_we && bus.wb_rd != '0)
      wb_vec[bus.wb_rd] = 1'b1;
  end

`ifdef DLX_WB_BYPASS_EN
  // A register completing writeback this cycle no longer blocks issue
  always_comb busy_eff = busy & ~wb_vec;

  // Operand reads forward the writeback value when it targets the source
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = wb_vec[rs1] ? bus.wb_data : regs[rs1];
    if (rs2 != '0) rs2_val = wb_vec[rs2] ? bus.wb_data : regs[rs2];
  end
`else
  // Hazards are judged against registered busy state only
  always_comb busy_eff = busy;

  // Operand reads come straight from the register file
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = regs[rs1];
    if (rs2 != '0) rs2_val = regs[rs2];
  end
`endif

  // Stall on a busy nonzero source or destination; illegal words never stall
  always_comb begin
    hazard = legal && (((rs1 != '0) && busy_eff[rs1]) ||
                       (is_r && (rs2 != '0) && busy_eff[rs2]) ||
                       ((rd != '0) && busy_eff[rd]));
  end

  assign bus.instr_ready = !hazard;
  assign xfer            = bus.instr_valid && !hazard;
  assign issue           = xfer && legal;

  // Second operand: register for R-type, extended immediate for I-type
  always_comb begin
    op2_sel = rs2_val;
    if (!is_r)
      op2_sel = zext ? zero_ext(imm) : sign_ext(imm);
  end

  // Scoreboard update: writeback clears, a new issue sets and wins
  always_comb begin
    busy_nxt = busy & ~wb_vec;
    if (issue && rd != '0)
      busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Register file write port; r0 stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (bus.wb_we && bus.wb_rd != '0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Issue stage p1: strobes pulse one cycle, command fields hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      i_p1       <= '0;
      op1_p1     <= '0;
      op2_p1     <= '0;
      dst_p1     <= '0;
    end else begin
      vld_p1     <= issue;
      illegal_p1 <= xfer && !legal;
      if (issue) begin
        i_p1   <= dec_op;
        op1_p1 <= rs1_val;
        op2_p1 <= op2_sel;
        dst_p1 <= rd;
      end
    end
  end

  assign bus.EX      = vld_p1;
  assign bus.illegal = illegal_p1;
  assign bus.I       = i_p1;
  assign bus.op1     = op1_p1;
  assign bus.op2     = op2_p1;
  assign bus.dst_rd  = dst_p1;

endmodule

// File: tb/tb_dlx_operand_stage.sv
// tb_dlx_operand_stage: directed checks of the DLX operand stage.
module tb_dlx_operand_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  dlx_operand_if #(.DATA_W(32), .REG_AW(5)) bus ();

  dlx_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.instr       = 32'h0;
    bus.instr_valid = 1'b0;
    bus.wb_we       = 1'b0;
    bus.wb_rd       = 5'd0;
    bus.wb_data     = 32'h0;
    #3;
    chk("rst_EX", {31'd0, bus.EX}, 32'd0);
    chk("rst_I", {28'd0, bus.I}, 32'd0);
    chk("rst_op1", bus.op1, 32'd0);
    chk("rst_op2", bus.op2, 32'd0);
    chk("rst_dst", {27'd0, bus.dst_rd}, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    chk("rst_busy", dut.busy, 32'd0);
    chk("rst_r1", dut.regs[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI r1,r0,-5
    bus.instr = 32'h2001FFFB; bus.instr_valid = 1'b1;
    #1 chk("addi_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("addi_EX", {31'd0, bus.EX}, 32'd1);
    chk("addi_I", {28'd0, bus.I}, 32'd1);
    chk("addi_op1", bus.op1, 32'd0);
    chk("addi_op2", bus.op2, 32'hFFFFFFFB);
    chk("addi_dst", {27'd0, bus.dst_rd}, 32'd1);
    chk("addi_busy1", {31'd0, dut.busy[1]}, 32'd1);

    // ORI r2,r0,0x8000 back-to-back
    @(negedge clk);
    bus.instr = 32'h34028000;
    #1 chk("ori_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("ori_EX", {31'd0, bus.EX}, 32'd1);
    chk("ori_I", {28'd0, bus.I}, 32'd4);
    chk("ori_op2", bus.op2, 32'h00008000);
    chk("ori_dst", {27'd0, bus.dst_rd}, 32'd2);

    // ADD r3,r1,r2 with both sources busy
    @(negedge clk);
    bus.instr = 32'h00221820;
    #1 chk("add_stall_ready", {31'd0, bus.instr_ready}, 32'd0);
    @(posedge clk); #1;
    chk("add_stall_EX", {31'd0, bus.EX}, 32'd0);
    chk("add_stall_I_hold", {28'd0, bus.I}, 32'd4);
    chk("add_stall_op2_hold", bus.op2, 32'h00008000);
    @(negedge clk);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'd9;
    #1 chk("add_wb2_ready", {31'd0, bus.instr_ready}, 32'd0);
    @(posedge clk); #1;
    chk("add_wb2_EX", {31'd0, bus.EX}, 32'd0);
    @(negedge clk);
    bus.wb_rd = 5'd1; bus.wb_data = 32'd7;
    #1;
`ifdef DLX_WB_BYPASS_EN
    chk("add_wb1_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk); #1;
`else
    chk("add_wb1_ready", {31'd0, bus.instr_ready}, 32'd0);
    @(posedge clk); #1;
    chk("add_wb1_EX", {31'd0, bus.EX}, 32'd0);
    @(negedge clk);
    bus.wb_we = 1'b0;
    #1 chk("add_after_wb_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk); #1;
`endif
    chk("add_EX", {31'd0, bus.EX}, 32'd1);
    chk("add_I", {28'd0, bus.I}, 32'd1);
    chk("add_op1", bus.op1, 32'd7);
    chk("add_op2", bus.op2, 32'd9);
    chk("add_dst", {27'd0, bus.dst_rd}, 32'd3);
    @(negedge clk);
    bus.wb_we = 1'b0; bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_EX", {31'd0, bus.EX}, 32'd0);

    // XOR r4,r0,r0 then SLL r5,r0,r0
    @(negedge clk);
    bus.instr = 32'h00002026; bus.instr_valid = 1'b1;
    #1 chk("xor_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("xor_EX", {31'd0, bus.EX}, 32'd1);
    chk("xor_I", {28'd0, bus.I}, 32'd5);
    chk("xor_dst", {27'd0, bus.dst_rd}, 32'd4);
    @(negedge clk);
    bus.instr = 32'h00002804;
    #1 chk("sll_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("sll_EX", {31'd0, bus.EX}, 32'd1);
    chk("sll_I", {28'd0, bus.I}, 32'd6);
    chk("sll_dst", {27'd0, bus.dst_rd}, 32'd5);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_EX", {31'd0, bus.EX}, 32'd0);

    // Illegal opcode 0x3F touching busy r3 / r1
    @(negedge clk);
    bus.instr = 32'hFC610000; bus.instr_valid = 1'b1;
    #1 chk("ill_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("ill_pulse", {31'd0, bus.illegal}, 32'd1);
    chk("ill_EX", {31'd0, bus.EX}, 32'd0);
    chk("ill_I_hold", {28'd0, bus.I}, 32'd6);
    chk("ill_busy", dut.busy, 32'h00000038);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("ill_end", {31'd0, bus.illegal}, 32'd0);

    // Writeback to a non-busy register, then to r0
    @(negedge clk);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h0000CAFE;
    @(posedge clk); #1;
    chk("wb_nonbusy_r9", dut.regs[9], 32'h0000CAFE);
    chk("wb_nonbusy_busy", dut.busy, 32'h00000038);
    @(negedge clk);
    bus.wb_rd = 5'd0; bus.wb_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("wb_r0", dut.regs[0], 32'd0);

    // ADDI r6,r0,1 issued while r6 is written back
    @(negedge clk);
    bus.instr = 32'h20060001; bus.instr_valid = 1'b1;
    bus.wb_rd = 5'd6; bus.wb_data = 32'h00001234;
    #1 chk("same_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("same_EX", {31'd0, bus.EX}, 32'd1);
    chk("same_op2", bus.op2, 32'd1);
    chk("same_dst", {27'd0, bus.dst_rd}, 32'd6);
    chk("same_busy6", {31'd0, dut.busy[6]}, 32'd1);
    chk("same_r6", dut.regs[6], 32'h00001234);

    // ADD r7,r6,r0 stalls, then asynchronous reset mid-stall
    @(negedge clk);
    bus.wb_we = 1'b0;
    bus.instr = 32'h00C03820;
    #1 chk("rst_stall_ready", {31'd0, bus.instr_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_EX", {31'd0, bus.EX}, 32'd0);
    chk("async_busy", dut.busy, 32'd0);
    chk("async_ready", {31'd0, bus.instr_ready}, 32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_EX", {31'd0, bus.EX}, 32'd1);
    chk("post_rst_I", {28'd0, bus.I}, 32'd1);
    chk("post_rst_op1", bus.op1, 32'd0);
    chk("post_rst_dst", {27'd0, bus.dst_rd}, 32'd7);
    chk("post_rst_busy7", {31'd0, dut.busy[7]}, 32'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
